// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser followed by a stability counter.
// A channel accepts a new level only after STABLE_CYCLES consecutive sample_en ticks
// on which the synchronised input differs from the current debounced level.
module debounce_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    // sync_q[0] samples the pins; sync_q[SYNC_STAGES-1] is the usable synchronised level
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    logic [CntW-1:0]     cnt_q [CHANNELS];
    logic [CntW-1:0]     cnt_d [CHANNELS];
    logic [CHANNELS-1:0] deb_q, deb_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic                any_q, any_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift register; runs every clock independent of sample_en
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int st = 0; st < int'(SYNC_STAGES); st++) begin
                sync_q[st] <= {CHANNELS{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= noisy;
            for (int st = 1; st < int'(SYNC_STAGES); st++) begin
                sync_q[st] <= sync_q[st-1];
            end
        end
    end

    // Per-channel stability counting and level acceptance
    always_comb begin
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int ch = 0; ch < int'(CHANNELS); ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (s[ch] == deb_q[ch]) begin
                // Agreement at any time clears progress, so short glitches are forgotten
                cnt_d[ch] = '0;
            end else if (sample_en) begin
                if (cnt_q[ch] == CntLast) begin
                    cnt_d[ch]  = '0;
                    deb_d[ch]  = s[ch];
                    rise_d[ch] = s[ch];
                    fall_d[ch] = ~s[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CntW'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    // Counter, level and strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                cnt_q[ch] <= '0;
            end
            deb_q  <= {CHANNELS{RESET_LEVEL}};
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign debounced  = deb_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed vector table, hand sequences for
// glitch/bounce/prescale/reset corners, and randomised traffic against a reference model.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int SC = 4;
    localparam int SS = 2;
    localparam bit RL = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_en;
    logic [CH-1:0] noisy;
    logic [CH-1:0] debounced;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic          any_change;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SS),
        .RESET_LEVEL   (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .noisy      (noisy),
        .debounced  (debounced),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    // Reference model: a queue delays raw samples by SS edges; each channel counts
    // consecutive enabled disagreeing samples and adopts the new level on the SC-th.
    logic [CH-1:0] m_pipe [$];
    logic [CH-1:0] m_deb;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    int            m_run [CH];

    int rise_seen [CH];
    int fall_seen [CH];
    bit both_seen;

    function automatic void model_edge(bit r, bit se, logic [CH-1:0] n);
        logic [CH-1:0] sv;
        m_rise = '0;
        m_fall = '0;
        if (r) begin
            m_pipe.delete();
            for (int i = 0; i < SS; i++) m_pipe.push_back({CH{RL}});
            m_deb = {CH{RL}};
            for (int c = 0; c < CH; c++) m_run[c] = 0;
            return;
        end
        sv = m_pipe.pop_front();
        m_pipe.push_back(n);
        for (int c = 0; c < CH; c++) begin
            if (sv[c] == m_deb[c]) begin
                m_run[c] = 0;
            end else if (se) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == SC) begin
                    m_run[c] = 0;
                    m_deb[c] = sv[c];
                    if (sv[c]) m_rise[c] = 1'b1;
                    else       m_fall[c] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later
    task automatic step(bit r, bit se, logic [CH-1:0] n);
        rst       = r;
        sample_en = se;
        noisy     = n;
        @(posedge clk);
        model_edge(r, se, n);
        #1;
        check("model", {debounced, rise_pulse, fall_pulse, any_change},
              {m_deb, m_rise, m_fall, |(m_rise | m_fall)});
        for (int c = 0; c < CH; c++) begin
            rise_seen[c] += int'(rise_pulse[c]);
            fall_seen[c] += int'(fall_pulse[c]);
        end
        if (rise_pulse == 4'b0001 && fall_pulse == 4'b1000) both_seen = 1'b1;
    endtask

    typedef struct {
        bit            r;
        bit            se;
        logic [CH-1:0] n;
        logic [CH-1:0] deb;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        bit            any;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [CH-1:0] base;
        int r0, f0, ticks, snap;
        bit fell;

        rst       = 1'b1;
        sample_en = 1'b1;
        noisy     = 4'hF;
        for (int c = 0; c < CH; c++) begin
            rise_seen[c] = 0;
            fall_seen[c] = 0;
        end
        both_seen = 1'b0;

        // Reset with pins high, one quiet cycle, then ch0 rises at row 4 (edge k)
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        for (int i = 4; i < 9; i++) tbl[i] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].se, tbl[i].n);
            check($sformatf("table[%0d]", i),
                  {debounced, rise_pulse, fall_pulse, any_change},
                  {tbl[i].deb, tbl[i].rise, tbl[i].fall, tbl[i].any});
        end
        base = 4'b0001;

        // Glitch of 3 clocks on ch1 is rejected; 4 clocks is accepted, then it falls
        r0 = rise_seen[1];
        f0 = fall_seen[1];
        repeat (3) step(1'b0, 1'b1, base | 4'b0010);
        repeat (6) step(1'b0, 1'b1, base);
        check("glitch3_no_rise", rise_seen[1] - r0, 0);
        check("glitch3_level", debounced[1], 1'b0);
        repeat (4) step(1'b0, 1'b1, base | 4'b0010);
        repeat (6) step(1'b0, 1'b1, base);
        check("glitch4_rise", rise_seen[1] - r0, 1);
        check("glitch4_fall", fall_seen[1] - f0, 1);

        // Bounce on ch2 then settle high: exactly one rise, no fall
        r0 = rise_seen[2];
        f0 = fall_seen[2];
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, base | ((i % 2 == 0) ? 4'b0100 : 4'b0000));
        base = base | 4'b0100;
        repeat (8) step(1'b0, 1'b1, base);
        check("bounce_rise", rise_seen[2] - r0, 1);
        check("bounce_fall", fall_seen[2] - f0, 0);

        // Prescaled sampling: ch3 needs 4 ticks to fall
        base = base | 4'b1000;
        repeat (8) step(1'b0, 1'b1, base);
        check("pre_ch3_high", debounced[3], 1'b1);
        base  = base & 4'b0111;
        ticks = 0;
        fell  = 1'b0;
        for (int i = 0; i < 40 && !fell; i++) begin
            step(1'b0, (i % 4 == 0), base);
            if (i >= SS && (i % 4 == 0)) ticks++;
            if (debounced[3] == 1'b0) fell = 1'b1;
        end
        check("prescale_fell", fell, 1'b1);
        check("prescale_ticks", ticks, 4);

        // Returning to the held level while sample_en is low clears progress
        r0 = rise_seen[3];
        repeat (5) step(1'b0, 1'b1, base | 4'b1000);
        repeat (4) step(1'b0, 1'b0, base);
        repeat (5) step(1'b0, 1'b1, base | 4'b1000);
        repeat (4) step(1'b0, 1'b0, base);
        repeat (4) step(1'b0, 1'b1, base);
        check("cnt_clear_no_rise", rise_seen[3] - r0, 0);
        check("cnt_clear_level", debounced[3], 1'b0);

        // Simultaneous ch0 rise and ch3 fall
        base = 4'b1000;
        repeat (8) step(1'b0, 1'b1, base);
        both_seen = 1'b0;
        base = 4'b0001;
        repeat (8) step(1'b0, 1'b1, base);
        check("simultaneous", both_seen, 1'b1);

        // Reset while counters sit at 2 abandons the pending transitions
        repeat (4) step(1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'hF);
        check("rst_mid_count", {debounced, rise_pulse, fall_pulse, any_change}, 0);
        snap = 0;
        for (int c = 0; c < CH; c++) snap += rise_seen[c] + fall_seen[c];
        repeat (8) step(1'b0, 1'b1, 4'h0);
        for (int c = 0; c < CH; c++) snap -= rise_seen[c] + fall_seen[c];
        check("rst_mid_no_strobe", snap, 0);

        // Random slowly-changing inputs with random ticks and rare resets
        base = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) base[$urandom_range(0, CH - 1)] ^= 1'b1;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), base);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
